// File: rtl/cordic_vec_arbiter.sv
// cordic_vec_arbiter
//   Shares one fully pipelined CORDIC vectoring datapath among N_REQ
//   requesters. One (x,y) sample is issued per cycle at most, picked
//   round-robin among eligible requesters. A valid/ID tag pipeline
//   matched to the datapath latency returns each phase tagged with the
//   requester that issued it. Results come back in issue order.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   hold       blocks new issue; in-flight samples still drain
//   req_valid  per-requester request valid
//   req_x      packed signed x samples, requester i at [i*W +: W]
//   req_y      packed signed y samples, same packing
//   req_ready  one-hot (or zero) grant
//   cdc_x      x sample to datapath (0 when nothing issued)
//   cdc_y      y sample to datapath (0 when nothing issued)
//   cdc_z      phase from datapath, LATENCY cycles after the sample
//   rsp_valid  single-cycle result strobe, no backpressure
//   rsp_id     requester owning the result
//   rsp_phase  result phase (0 when rsp_valid is low)
//   busy       high while any sample is in flight
module cordic_vec_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WORD_WIDTH  = 16,
  parameter int PHASE_WIDTH = 16,
  parameter int LATENCY     = 15,
  parameter int MAX_OUTST   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hold,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*WORD_WIDTH-1:0]   req_x,
  input  logic [N_REQ*WORD_WIDTH-1:0]   req_y,
  output logic [N_REQ-1:0]              req_ready,
  output logic [WORD_WIDTH-1:0]         cdc_x,
  output logic [WORD_WIDTH-1:0]         cdc_y,
  input  logic [PHASE_WIDTH-1:0]        cdc_z,
  output logic                          rsp_valid,
  output logic [$clog2(N_REQ)-1:0]      rsp_id,
  output logic [PHASE_WIDTH-1:0]        rsp_phase,
  output logic                          busy
);

  localparam int unsigned NR  = N_REQ;
  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned CW  = $clog2(MAX_OUTST + 1);
  localparam int unsigned LAT = LATENCY;

  logic [IDW-1:0]   rr_ptr;
  logic [CW-1:0]    outst [NR];
  logic [NR-1:0]    eligible;
  logic [NR-1:0]    retire;
  logic [NR-1:0]    grant;
  logic             grant_any;
  logic [IDW-1:0]   grant_id;
  logic [LAT-1:0]   tag_vld;
  logic [IDW-1:0]   tag_id [LAT];

  // Retire decode from the last tag stage
  always_comb begin
    retire = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      retire[i] = tag_vld[LAT-1] && (tag_id[LAT-1] == IDW'(i));
    end
  end

  // A retire this cycle frees a slot immediately, so a requester sitting
  // at MAX_OUTST may issue in the same cycle its oldest sample returns.
  // Eligibility is also gated by rst so no grant is shown during reset.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      eligible[i] = rst & req_valid[i] & ~hold &
                    ((int'(outst[i]) < MAX_OUTST) | retire[i]);
    end
  end

  // Round-robin: first eligible at or after rr_ptr, wrapping upward
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NR) idx = idx - NR;
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (grant_any) grant[grant_id] = 1'b1;
  end

  assign req_ready = grant;

  always_comb begin
    cdc_x = '0;
    cdc_y = '0;
    if (grant_any) begin
      cdc_x = req_x[int'(grant_id)*WORD_WIDTH +: WORD_WIDTH];
      cdc_y = req_y[int'(grant_id)*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      if (int'(grant_id) == N_REQ - 1) rr_ptr <= '0;
      else                             rr_ptr <= grant_id + 1'b1;
    end
  end

  // Tag pipeline shifts every cycle; the datapath never stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld <= '0;
      for (int unsigned k = 0; k < LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_vld[0] <= grant_any;
      tag_id[0]  <= grant_id;
      for (int unsigned k = 1; k < LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NR; i++) outst[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NR; i++) begin
        if (grant[i] && !retire[i])      outst[i] <= outst[i] + 1'b1;
        else if (!grant[i] && retire[i]) outst[i] <= outst[i] - 1'b1;
      end
    end
  end

  assign rsp_valid = tag_vld[LAT-1];
  assign rsp_id    = tag_id[LAT-1];
  assign rsp_phase = rsp_valid ? cdc_z : '0;
  assign busy      = |tag_vld;

endmodule

// File: tb/tb_cordic_vec_arbiter.sv
module tb_cordic_vec_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int PW  = 16;
  localparam int LAT = 15;
  localparam int MO  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           hold = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_x, req_y;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   cdc_x, cdc_y;
  logic [PW-1:0]  cdc_z;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [PW-1:0]  rsp_phase;
  logic           busy;

  always #5 clk = ~clk;

  cordic_vec_arbiter #(
    .N_REQ(N), .WORD_WIDTH(W), .PHASE_WIDTH(PW), .LATENCY(LAT), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .cdc_x(cdc_x), .cdc_y(cdc_y), .cdc_z(cdc_z),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_phase(rsp_phase), .busy(busy)
  );

  logic [W-1:0] sx [N];
  logic [W-1:0] sy [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_x[i*W +: W] = sx[i];
      req_y[i*W +: W] = sy[i];
    end
  end

  // Stand-in datapath: z = x + 2*y, LAT cycles later; never reset
  logic [PW-1:0] dp [LAT];
  always @(posedge clk) begin
    dp[0] <= cdc_x + (cdc_y << 1);
    for (int k = 1; k < LAT; k++) dp[k] <= dp[k-1];
  end
  assign cdc_z = dp[LAT-1];

  function automatic logic [15:0] fz(input logic [15:0] x, input logic [15:0] y);
    return x + (y << 1);
  endfunction

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] ph;
    logic [31:0] cy;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard whenever a result is presented
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_phase", 32'(rsp_phase), 32'(e.ph));
          chk("rsp_latency", cyc, e.cy + LAT);
        end
      end else begin
        chk("rsp_phase_idle", 32'(rsp_phase), 32'd0);
      end
    end
  end

  // One cycle of stimulus, starting 1 time unit after a rising edge.
  // eb < 0 skips the busy check.
  task automatic step(input logic [3:0] v, input logic h, input logic [3:0] er, input int eb);
    exp_t e;
    int   id;
    req_valid = v;
    hold      = h;
    #3;
    chk("req_ready", 32'(req_ready), 32'(er));
    if (eb >= 0) chk("busy", 32'(busy), 32'(eb));
    if (er != 0) begin
      id = 0;
      for (int i = 0; i < N; i++) if (er[i]) id = i;
      chk("cdc_x", 32'(cdc_x), 32'(sx[id]));
      chk("cdc_y", 32'(cdc_y), 32'(sy[id]));
      e.id = 2'(id);
      e.ph = fz(sx[id], sy[id]);
      e.cy = cyc;
      q.push_back(e);
    end else begin
      chk("cdc_x_idle", 32'(cdc_x), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (LAT + 1) step(4'b0000, 1'b0, 4'b0000, -1);
    step(4'b0000, 1'b0, 4'b0000, 0);
  endtask

  initial begin
    sx[0] = 16'd1000;  sy[0] = 16'hFFCE;  // ( 1000, -50)
    sx[1] = 16'hFF38;  sy[1] = 16'd300;   // (-200,  300)
    sx[2] = 16'd100;   sy[2] = 16'd100;   // ( 100,  100)
    sx[3] = 16'd7;     sy[3] = 16'hFFF7;  // (   7,   -9)

    // Reset state with every requester asking
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cdc_x", 32'(cdc_x), 32'd0);
    rst = 1'b1;

    // Single request from requester 2; busy high for exactly LAT cycles
    step(4'b0100, 1'b0, 4'b0100, 0);
    for (int k = 1; k <= LAT + 1; k++) step(4'b0000, 1'b0, 4'b0000, (k <= LAT) ? 1 : 0);

    // rr_ptr=3: grant 3, then wrap to 0, then 3
    step(4'b1000, 1'b0, 4'b1000, -1);
    step(4'b1001, 1'b0, 4'b0001, -1);
    step(4'b1001, 1'b0, 4'b1000, -1);
    drain();

    // All requesters valid: strict 0,1,2,3 rotation with no stall
    for (int k = 0; k < 22; k++) step(4'b1111, 1'b0, 4'(1 << (k % 4)), -1);

    // Hold for 20 cycles: no grants, pipeline drains, rr_ptr stays at 2
    for (int k = 1; k <= 20; k++) step(4'b1111, 1'b1, 4'b0000, (k <= LAT) ? 1 : 0);
    step(4'b1111, 1'b0, 4'b0100, 0);
    step(4'b1111, 1'b0, 4'b1000, 1);
    drain();

    // Requester 1 alone: MO back-to-back, stall, resume on each retire
    repeat (MO) step(4'b0010, 1'b0, 4'b0010, -1);
    repeat (LAT - MO) step(4'b0010, 1'b0, 4'b0000, -1);
    repeat (MO) step(4'b0010, 1'b0, 4'b0010, -1);
    step(4'b0010, 1'b0, 4'b0000, -1);
    drain();

    // Reset mid-operation: three issues in flight, then reset
    step(4'b0111, 1'b0, 4'b0100, -1);
    step(4'b0111, 1'b0, 4'b0001, -1);
    step(4'b0111, 1'b0, 4'b0010, -1);
    repeat (5) step(4'b0000, 1'b0, 4'b0000, 1);
    req_valid = 4'b1111;
    rst = 1'b0;
    #1;
    q.delete();
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (LAT + 1) step(4'b0000, 1'b0, 4'b0000, 0);
    // Requester 0 had one sample outstanding before reset; a full
    // MO burst proves its counter was cleared
    repeat (MO) step(4'b0001, 1'b0, 4'b0001, -1);
    step(4'b0001, 1'b0, 4'b0000, -1);
    step(4'b0100, 1'b0, 4'b0100, -1);
    drain();

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
